// File: rtl/spi_master.sv
// Byte-level SPI mode-3 master: serialises controller bytes onto SCLK/MOSI with
// per-sensor chip select, returning each MISO byte alongside a write_ready pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | CS released, SCLK/MOSI high, waiting for write_start
// SETUP    | CS asserted, waiting CS_SETUP cycles before first SCLK fall
// SHIFT_LO | SCLK low, MOSI presents current bit
// SHIFT_HI | SCLK high, MISO captured and TX shifted on entry cycle
// DONE     | one-cycle write_ready/read_valid pulse, byte count decrements
// LOAD     | next controller byte latched into the TX shifter
// HOLD     | CS held CS_HOLD cycles after final SCLK rise
module spi_master #(
    parameter int HALF_PERIOD = 2,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_select,
    input  logic       write_start,
    input  logic [7:0] write_data,
    input  logic [2:0] write_count_bytes,
    output logic       write_ready,
    output logic [7:0] read_data,
    output logic       read_valid,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [1:0] spi_cs_n
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        DONE,
        LOAD,
        HOLD
    } state_t;

    localparam logic [15:0] HP_LOAD    = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] SETUP_LOAD = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LOAD  = 16'(CS_HOLD - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_next;
    logic [2:0]  remaining;
    logic [2:0]  rem_next;
    logic [7:0]  tx_shift;
    logic [7:0]  tx_next;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_next;
    logic        sel;
    logic        sel_next;
    logic [1:0]  cs_next;
    logic        sclk_next;
    logic        mosi_next;
    logic        ready_next;
    logic        busy_next;
    logic [7:0]  rdata_next;

    always_comb begin
        state_next = state;
        cnt_next   = (cnt != 16'd0) ? cnt - 16'd1 : 16'd0;
        bit_next   = bit_cnt;
        rem_next   = remaining;
        tx_next    = tx_shift;
        rx_next    = rx_shift;
        sel_next   = sel;

        case (state)
            IDLE: begin
                if (write_start && (write_count_bytes != 3'd0)) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LOAD;
                    sel_next   = sensor_select;
                    rem_next   = write_count_bytes;
                    tx_next    = write_data;
                end
            end
            SETUP: begin
                if (cnt == 16'd0) begin
                    state_next = SHIFT_LO;
                    cnt_next   = HP_LOAD;
                    bit_next   = 3'd0;
                end
            end
            SHIFT_LO: begin
                if (cnt == 16'd0) begin
                    state_next = SHIFT_HI;
                    cnt_next   = HP_LOAD;
                end
            end
            SHIFT_HI: begin
                // Entry cycle: SCLK has just risen, so MISO is sampled here
                if (cnt == HP_LOAD) begin
                    rx_next = {rx_shift[6:0], spi_miso};
                    tx_next = {tx_shift[6:0], 1'b0};
                end
                if (cnt == 16'd0) begin
                    cnt_next = HP_LOAD;
                    if (bit_cnt == 3'd7) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT_LO;
                        bit_next   = bit_cnt + 3'd1;
                    end
                end
            end
            DONE: begin
                rem_next = remaining - 3'd1;
                if (remaining == 3'd1) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end else begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SHIFT_LO;
                cnt_next   = HP_LOAD;
                bit_next   = 3'd0;
                tx_next    = write_data;
            end
            HOLD: begin
                if (cnt == 16'd0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered from the next state so the pins never glitch
        cs_next    = (state_next == IDLE) ? 2'b11 : (sel_next ? 2'b01 : 2'b10);
        sclk_next  = (state_next != SHIFT_LO);
        mosi_next  = spi_mosi;
        if (state_next == SHIFT_LO) begin
            mosi_next = tx_next[7];
        end else if (state_next == IDLE) begin
            mosi_next = 1'b1;
        end
        ready_next = (state_next == DONE);
        busy_next  = (state_next != IDLE);
        rdata_next = (state_next == DONE) ? rx_next : read_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            bit_cnt     <= 3'd0;
            remaining   <= 3'd0;
            tx_shift    <= 8'd0;
            rx_shift    <= 8'd0;
            sel         <= 1'b0;
            spi_cs_n    <= 2'b11;
            spi_sclk    <= 1'b1;
            spi_mosi    <= 1'b1;
            write_ready <= 1'b0;
            busy        <= 1'b0;
            read_data   <= 8'd0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bit_cnt     <= bit_next;
            remaining   <= rem_next;
            tx_shift    <= tx_next;
            rx_shift    <= rx_next;
            sel         <= sel_next;
            spi_cs_n    <= cs_next;
            spi_sclk    <= sclk_next;
            spi_mosi    <= mosi_next;
            write_ready <= ready_next;
            busy        <= busy_next;
            read_data   <= rdata_next;
        end
    end

    assign read_valid = write_ready;

endmodule
